// File: rtl/custom_divide.sv
// Nios II multicycle custom instruction: unsigned restoring shift-subtract divider.
// Define CUSTOM_DIV_REMAINDER_EN to add the n port, which selects remainder (n=1) or quotient (n=0).
module custom_divide #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             start,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
`ifdef CUSTOM_DIV_REMAINDER_EN
    input  logic             n,
`endif
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CALC   = 2'd1,
        S_FINISH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic             sel_in;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH:0]   trial;

`ifdef CUSTOM_DIV_REMAINDER_EN
    assign sel_in = n;
`else
    assign sel_in = 1'b0;
`endif

    // State, datapath and output registers; clk_en freezes everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            quot_q   <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            count_q  <= '0;
            sel_q    <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            count_q  <= count_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    // Next-state logic and one restoring-division step per CALC cycle.
    always_comb begin
        state_d  = state_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        div_d    = div_q;
        count_d  = count_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        result_d = result_q;

        rem_s = {rem_q[WIDTH-2:0], quot_q[WIDTH-1]};
        trial = {1'b0, rem_s} - {1'b0, div_q};

        unique case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse waits one more cycle.
                if (start && !done_q) begin
                    sel_d   = sel_in;
                    div_d   = datab;
                    count_d = CW'(WIDTH);
                    if (datab == '0) begin
                        quot_d  = '1;
                        rem_d   = dataa;
                        state_d = S_FINISH;
                    end else begin
                        quot_d  = dataa;
                        rem_d   = '0;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                quot_d  = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d   = trial[WIDTH] ? rem_s : trial[WIDTH-1:0];
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                done_d   = 1'b1;
                result_d = sel_q ? rem_q : quot_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_custom_divide.sv
// Self-checking bench for custom_divide: arithmetic reference model plus directed literal vectors.
// Honours CUSTOM_DIV_REMAINDER_EN when defined for the build.
module tb_custom_divide;

    localparam int unsigned WIDTH = 32;
`ifdef CUSTOM_DIV_REMAINDER_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             clk_en;
    logic             start;
    logic [WIDTH-1:0] dataa;
    logic [WIDTH-1:0] datab;
    logic             n_r;
    logic             done;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    custom_divide #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .start  (start),
        .dataa  (dataa),
        .datab  (datab),
`ifdef CUSTOM_DIV_REMAINDER_EN
        .n      (n_r),
`endif
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic sel);
        if (b == 32'd0) return sel ? a : 32'hFFFF_FFFF;
        return sel ? (a % b) : (a / b);
    endfunction

    // Reference model: an accepted divide completes 33 enabled edges later (1 for divide-by-zero).
    logic        exp_done = 1'b0;
    logic [31:0] exp_result = 32'd0;
    bit          m_busy = 1'b0;
    int          m_left = 0;
    logic [31:0] m_pending = 32'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy     = 1'b0;
            m_left     = 0;
            exp_done   = 1'b0;
            exp_result = 32'd0;
        end else if (clk_en) begin
            bit prev_done;
            prev_done = exp_done;
            exp_done  = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy     = 1'b0;
                    exp_done   = 1'b1;
                    exp_result = m_pending;
                end
            end else if (start && !prev_done) begin
                m_busy    = 1'b1;
                m_left    = (datab == 32'd0) ? 1 : WIDTH + 1;
                m_pending = ref_div(dataa, datab, REM_EN && n_r);
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("cyc_done", 32'(done), 32'(exp_done));
            chk("cyc_result", result, exp_result);
        end
    end

    // One divide with optional clk_en stall, stray start pulse, or mid-operation reset.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic nn,
                           input logic [31:0] exp_r, input int exp_edges,
                           input int stall_at, input int stall_len,
                           input int repulse_at, input int reset_at);
        int edges;
        bit seen;
        bit aborted;
        @(negedge clk);
        start = 1'b1; dataa = a; datab = b; n_r = nn;
        @(negedge clk);
        start = 1'b0; dataa = 32'($urandom); datab = 32'($urandom); n_r = 1'($urandom);
        edges = 1; seen = 1'b0; aborted = 1'b0;
        while (!seen && !aborted && edges < 200) begin
            if (done) begin
                seen = 1'b1;
            end else if (edges == reset_at) begin
                reset = 1'b1;
                #1;
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_result", result, 32'd0);
                @(negedge clk);
                reset   = 1'b0;
                aborted = 1'b1;
            end else begin
                if (edges == stall_at) clk_en = 1'b0;
                if (edges == stall_at + stall_len) clk_en = 1'b1;
                if (edges == repulse_at) begin
                    start = 1'b1; dataa = 32'd7; datab = 32'd1;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                edges++;
            end
        end
        start  = 1'b0;
        clk_en = 1'b1;
        if (!aborted) begin
            chk("done_seen", 32'(seen), 32'd1);
            chk("latency", 32'(edges), 32'(exp_edges));
            chk("result", result, exp_r);
            @(negedge clk);
            chk("done_drop", 32'(done), 32'd0);
            chk("result_hold", result, exp_r);
        end
    endtask

    initial begin
        int edges;
        reset = 1'b1; clk_en = 1'b1; start = 1'b0;
        dataa = 32'd0; datab = 32'd0; n_r = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_div(32'd100, 32'd7, 1'b0, 32'd14, 34, 0, 0, 0, 0);
        run_div(32'd100, 32'd7, 1'b1, REM_EN ? 32'd2 : 32'd14, 34, 0, 0, 0, 0);
        run_div(32'd5, 32'd9, 1'b1, REM_EN ? 32'd5 : 32'd0, 34, 0, 0, 0, 0);
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 34, 0, 0, 0, 0);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 34, 0, 0, 0, 0);
        run_div(32'd1000000, 32'd3, 1'b0, 32'd333333, 34, 0, 0, 0, 0);
        run_div(32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 2, 0, 0, 0, 0);
        run_div(32'h0000_1234, 32'd0, 1'b1, REM_EN ? 32'h0000_1234 : 32'hFFFF_FFFF, 2, 0, 0, 0, 0);
        run_div(32'd123, 32'd10, 1'b0, 32'd12, 39, 10, 5, 20, 0);
        run_div(32'd1000, 32'd3, 1'b0, 32'd0, 0, 0, 0, 0, 10);
        run_div(32'd9, 32'd3, 1'b0, 32'd3, 34, 0, 0, 0, 0);

        // start held high: the cycle carrying done must not be accepted.
        @(negedge clk);
        start = 1'b1; dataa = 32'd20; datab = 32'd4; n_r = 1'b0;
        edges = 0;
        do begin @(negedge clk); edges++; end while (!done && edges < 100);
        chk("b2b_first", 32'(edges), 32'd34);
        edges = 0;
        do begin @(negedge clk); edges++; end while (!done && edges < 100);
        start = 1'b0;
        chk("b2b_second", 32'(edges), 32'd35);
        chk("b2b_result", result, 32'd5);

        repeat (50) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
